// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Imported by the interface, the round-robin picker and the top.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beat_w(input int m);
    return $clog2(m + 1);
  endfunction

  localparam int OWNER_W = owner_w(4);
  localparam int BEAT_W  = beat_w(8);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signal bundle of the write arbiter.
// slave = arbiter view, master = producers/FIFO view.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 22,
  parameter int OWNER_W = owner_w(NUM_REQ),
  parameter int BEAT_W  = beat_w(8)
);

  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ-1:0]       last_i;
  logic [NUM_REQ*WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]       mask_i;
  logic                     full_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic                     wr_en_o;
  logic [WIDTH-1:0]         wdata_o;
  logic [OWNER_W-1:0]       owner_o;
  logic                     busy_o;
  logic [BEAT_W-1:0]        beat_cnt_o;

  modport slave (
    input  req_i, last_i, data_i,
    input  mask_i, full_i,
    output gnt_o, wr_en_o, wdata_o,
    output owner_o, busy_o, beat_cnt_o
  );

  modport master (
    output req_i, last_i, data_i,
    output mask_i, full_i,
    input  gnt_o, wr_en_o, wdata_o,
    input  owner_o, busy_o, beat_cnt_o
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority find-first: first candidate above ptr_i,
// wrapping modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OW      = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] cand_i,
  input  logic [OW-1:0]      ptr_i,
  output logic [OW-1:0]      idx_o,
  output logic               vld_o
);

  int pos;

  // Scan farthest-first so the nearest hit overwrites.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    pos   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = (int'(ptr_i) + k) % NUM_REQ;
      if (cand_i[pos]) begin
        idx_o = OW'(pos);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst round-robin arbiter sharing one async FIFO write port
// among NUM_REQ producers, gated by FIFO full back-pressure.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 22,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input logic             clk_i,
  input logic             rst_ni,
  fifo_wr_arbiter_if.slave bus
);

  localparam int OW = owner_w(NUM_REQ);
  localparam int BW = beat_w(MAX_BURST);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic ST_IDLE  = IDLE;
  localparam logic ST_BURST = BURST;

  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);

  logic               state_q;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      rr_ptr_q;
  logic [BW-1:0]      beat_q;
  logic [IW-1:0]      idle_q;

  logic [NUM_REQ-1:0] cand;
  logic [OW-1:0]      win_idx;
  logic               win_vld;

  logic               busy;
  logic               open;
  logic               own_req;
  logic               beat;
  logic [BW-1:0]      beat_inc;
  logic [IW-1:0]      idle_inc;
  logic               hit_last;
  logic               hit_max;
  logic               hit_idle;
  logic               rel;
  logic [NUM_REQ-1:0] gnt;

  assign cand = bus.req_i & bus.mask_i;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OW      (OW)
  ) u_pick (
    .cand_i (cand),
    .ptr_i  (rr_ptr_q),
    .idx_o  (win_idx),
    .vld_o  (win_vld)
  );

  assign busy     = (state_q == ST_BURST);
  assign open     = busy && !bus.full_i;
  assign own_req  = bus.req_i[owner_q];
  assign beat     = open && own_req;
  assign beat_inc = beat_q + BW'(1);
  assign idle_inc = idle_q + IW'(1);

  assign hit_last = beat && bus.last_i[owner_q];
  assign hit_max  = beat && (beat_inc == BEAT_MAX);
  // Back-pressure stalls never advance the idle timer.
  assign hit_idle = open && !own_req
                 && (idle_inc == IDLE_MAX);
  assign rel      = hit_last || hit_max || hit_idle;

  always_comb begin
    gnt          = '0;
    gnt[owner_q] = open;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= OW'(NUM_REQ - 1);
      owner_q  <= '0;
      beat_q   <= '0;
      idle_q   <= '0;
    end else begin
      unique case (1'b1)
        !busy: begin
          if (win_vld) begin
            state_q <= ST_BURST;
            owner_q <= win_idx;
            beat_q  <= '0;
            idle_q  <= '0;
          end
        end
        busy: begin
          if (beat) beat_q <= beat_inc;
          if (own_req) begin
            idle_q <= '0;
          end else if (!bus.full_i) begin
            idle_q <= idle_inc;
          end
          if (rel) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= owner_q;
          end
        end
      endcase
    end
  end

  assign bus.gnt_o      = gnt;
  assign bus.wr_en_o    = beat;
  assign bus.wdata_o    = bus.data_i[int'(owner_q)*WIDTH +: WIDTH];
  assign bus.owner_o    = owner_q;
  assign bus.busy_o     = busy;
  assign bus.beat_cnt_o = beat_q;

endmodule
